// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU: op-codes, slice function selects and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    OR   = 3'b010,
    ORN  = 3'b011,
    AND  = 3'b100,
    ANDN = 3'b101,
    NOTA = 3'b110,
    NOTB = 3'b111
  } op_e;

  // op[2:1] picks the slice function; op[0] inverts B.
  localparam logic [1:0] SEL_SUM = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_bitslice.sv
// One-bit ALU slice: full adder plus OR/AND/NOT, with optional inversion of B.
module alu_bitslice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] ctrl,
  output logic       y,
  output logic       cout
);

  logic b_eff;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    b_eff = b ^ ctrl[0];
    y     = 1'b0;
    cout  = 1'b0;
    unique case (ctrl[2:1])
      SEL_SUM: begin
        y    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (cin & (a ^ b_eff));
      end
      SEL_OR:  y = a | b_eff;
      SEL_AND: y = a & b_eff;
      SEL_NOT: y = ctrl[0] ? b_eff : ~a;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one result bit per clock, LSB first, through a single alu_bitslice.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output logic             v_flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d, res_next;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d;
  logic             slice_y, slice_cout, arith;

  alu_bitslice u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .ctrl (op_q),
    .y    (slice_y),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    v_d      = v_q;
    res_next = {slice_y, res_sh_q[WIDTH-1:1]};
    arith    = (op_q[2:1] == SEL_SUM);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          op_d    = op;
          cnt_d   = '0;
          carry_d = (op == SUB);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB, slice_cout the carry out of it.
          state_d  = DONE;
          result_d = res_next;
          z_d      = (res_next == '0);
          c_d      = arith & slice_cout;
          v_d      = arith & (carry_q ^ slice_cout);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      v_q      <= v_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign c_flag = c_q;
  assign z_flag = z_q;
  assign v_flag = v_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed ops push expected results, a monitor checks each done.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] result;
  logic         c_flag, z_flag, v_flag;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .v_flag (v_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("done_with_pending_op", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("result", 32'(result), 32'(e.r));
        check("c_flag", 32'(c_flag), 32'(e.c));
        check("z_flag", 32'(z_flag), 32'(e.z));
        check("v_flag", 32'(v_flag), 32'(e.v));
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit wait_edge, input bit mid_pulse);
    int n;
    int busy_n;
    sb_q.push_back(e);
    if (wait_edge) @(posedge clk);
    #1;
    start = 1'b1; op = o; a_in = a; b_in = b;
    n = 0; busy_n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) start = 1'b0;
      if (mid_pulse && n == 3) begin
        start = 1'b1; op = ADD; a_in = 8'hAA; b_in = 8'h11;
      end
      if (mid_pulse && n == 4) start = 1'b0;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) break;
    end
    check("done_latency", n, W + 1);
    check("busy_cycles", busy_n, W);
    repeat (2) @(negedge clk);
    check("result_hold", 32'(result), 32'(e.r));
  endtask

  initial begin
    int n;
    int k;
    int done_at[3];

    rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    #12;
    check("rst_busy",   32'(busy),   0);
    check("rst_done",   32'(done),   0);
    check("rst_result", 32'(result), 0);
    check("rst_flags",  32'({c_flag, z_flag, v_flag}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(ADD,  8'h7F, 8'h01, exp_t'{8'h80, 1'b0, 1'b0, 1'b1}, 1'b1, 1'b0);
    run_op(SUB,  8'h05, 8'h05, exp_t'{8'h00, 1'b1, 1'b1, 1'b0}, 1'b1, 1'b1);
    run_op(SUB,  8'h00, 8'h01, exp_t'{8'hFF, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    run_op(ANDN, 8'hF0, 8'h3C, exp_t'{8'hC0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    run_op(ORN,  8'h00, 8'hFF, exp_t'{8'h00, 1'b0, 1'b1, 1'b0}, 1'b1, 1'b0);
    run_op(NOTB, 8'h55, 8'h0F, exp_t'{8'hF0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    run_op(OR,   8'hA0, 8'h05, exp_t'{8'hA5, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    run_op(AND,  8'hF3, 8'h3F, exp_t'{8'h33, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    run_op(NOTA, 8'h3C, 8'h00, exp_t'{8'hC3, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0);
    run_op(ADD,  8'hFF, 8'h01, exp_t'{8'h00, 1'b1, 1'b1, 1'b0}, 1'b1, 1'b0);
    run_op(ADD,  8'h80, 8'h80, exp_t'{8'h00, 1'b1, 1'b1, 1'b1}, 1'b1, 1'b0);

    // Abandon an operation with reset in its fourth RUN cycle.
    @(posedge clk);
    #1;
    start = 1'b1; op = ADD; a_in = 8'h40; b_in = 8'h40;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   32'(busy),   0);
    check("async_rst_done",   32'(done),   0);
    check("async_rst_result", 32'(result), 0);
    check("async_rst_flags",  32'({c_flag, z_flag, v_flag}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(ADD, 8'h01, 8'h01, exp_t'{8'h02, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b0);

    // Back-to-back operations with start held high through DONE.
    sb_q.push_back(exp_t'{8'h46, 1'b0, 1'b0, 1'b0});
    sb_q.push_back(exp_t'{8'hF0, 1'b0, 1'b0, 1'b0});
    sb_q.push_back(exp_t'{8'h00, 1'b0, 1'b1, 1'b0});
    foreach (done_at[i]) done_at[i] = 0;
    @(posedge clk);
    #1;
    start = 1'b1; op = ADD; a_in = 8'h12; b_in = 8'h34;
    n = 0; k = 0;
    while (n < 40 && k < 3) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1)  begin op = SUB; a_in = 8'h10; b_in = 8'h20; end
      if (n == 10) begin op = AND; a_in = 8'hFF; b_in = 8'h00; end
      if (n == 19) start = 1'b0;
      @(negedge clk);
      if (done) begin
        done_at[k] = n;
        k++;
      end
    end
    check("b2b_done_count", k, 3);
    check("b2b_done_0", done_at[0], 9);
    check("b2b_done_1", done_at[1], 18);
    check("b2b_done_2", done_at[2], 27);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
